// File: rtl/cpu16_pkg.sv
// rtl/cpu16_pkg.sv - shared widths, types and helpers for the 16-bit CPU register file
package cpu16_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_IDX_W = 4;
  localparam int NUM_REGS  = 16;
  localparam int NUM_LANES = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    word_t;
  typedef logic [1:0]           lane_idx_t;

  // One-hot decode of a register index into a 16-bit mask
  function automatic logic [NUM_REGS-1:0] onehot16(input reg_idx_t idx);
    logic [NUM_REGS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-way round-robin arbiter owning the rotating priority pointer
module rr_arbiter4
  import cpu16_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);

  lane_idx_t r_ptr;
  lane_idx_t w_idx;
  logic      w_found;

  // First requester at or after r_ptr wins; no grant while reset is held
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_idx = r_ptr + lane_idx_t'(i);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
        w_found    = 1'b1;
      end
    end
    if (!rst_n) begin
      gnt = '0;
    end
  end

  // Pointer moves just past the winner so it gets lowest priority next time
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (|gnt) begin
      r_ptr <= gnt_idx + 2'd1;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - write-back arbitration and architectural register array
module regfile_writeback #(
  parameter int DATA_W    = cpu16_pkg::DATA_W,
  parameter int NUM_REGS  = cpu16_pkg::NUM_REGS,
  parameter int NUM_LANES = cpu16_pkg::NUM_LANES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_valid_d0,
  input  logic                wb_valid_d1,
  input  logic                wb_valid_d2,
  input  logic                wb_valid_d3,
  input  logic [3:0]          wb_rd_d0,
  input  logic [3:0]          wb_rd_d1,
  input  logic [3:0]          wb_rd_d2,
  input  logic [3:0]          wb_rd_d3,
  input  logic [DATA_W-1:0]   wb_data_d0,
  input  logic [DATA_W-1:0]   wb_data_d1,
  input  logic [DATA_W-1:0]   wb_data_d2,
  input  logic [DATA_W-1:0]   wb_data_d3,
  output logic                wb_ready_d0,
  output logic                wb_ready_d1,
  output logic                wb_ready_d2,
  output logic                wb_ready_d3,
  output logic [DATA_W-1:0]   x0,
  output logic [DATA_W-1:0]   x1,
  output logic [DATA_W-1:0]   x2,
  output logic [DATA_W-1:0]   x3,
  output logic [DATA_W-1:0]   x4,
  output logic [DATA_W-1:0]   x5,
  output logic [DATA_W-1:0]   x6,
  output logic [DATA_W-1:0]   x7,
  output logic [DATA_W-1:0]   x8,
  output logic [DATA_W-1:0]   x9,
  output logic [DATA_W-1:0]   x10,
  output logic [DATA_W-1:0]   x11,
  output logic [DATA_W-1:0]   x12,
  output logic [DATA_W-1:0]   x13,
  output logic [DATA_W-1:0]   x14,
  output logic [DATA_W-1:0]   x15,
  output logic [NUM_REGS-1:0] pending,
  output logic                wb_busy
);

  logic [NUM_LANES-1:0]     w_valid;
  cpu16_pkg::reg_idx_t      w_rd   [NUM_LANES];
  logic [DATA_W-1:0]        w_data [NUM_LANES];
  logic [NUM_LANES-1:0]     w_gnt;
  logic [1:0]               w_gnt_idx;
  logic                     w_we;
  cpu16_pkg::reg_idx_t      w_sel_rd;
  logic [DATA_W-1:0]        w_sel_data;
  logic [DATA_W-1:0]        r_x [1:NUM_REGS-1];

  assign w_valid = {wb_valid_d3, wb_valid_d2, wb_valid_d1, wb_valid_d0};
  assign w_rd[0] = wb_rd_d0;
  assign w_rd[1] = wb_rd_d1;
  assign w_rd[2] = wb_rd_d2;
  assign w_rd[3] = wb_rd_d3;
  assign w_data[0] = wb_data_d0;
  assign w_data[1] = wb_data_d1;
  assign w_data[2] = wb_data_d2;
  assign w_data[3] = wb_data_d3;

  rr_arbiter4 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_valid),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign wb_ready_d0 = w_gnt[0];
  assign wb_ready_d1 = w_gnt[1];
  assign wb_ready_d2 = w_gnt[2];
  assign wb_ready_d3 = w_gnt[3];

  assign w_we       = |w_gnt;
  assign w_sel_rd   = w_rd[w_gnt_idx];
  assign w_sel_data = w_data[w_gnt_idx];

  // Commit the granted lane; x0 has no storage so rd=0 writes just drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        r_x[r] <= '0;
      end
    end else if (w_we) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_sel_rd == cpu16_pkg::reg_idx_t'(r)) begin
          r_x[r] <= w_sel_data;
        end
      end
    end
  end

  // Hazard mask: every register some lane is still trying to write
  always_comb begin
    pending = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (w_valid[l]) begin
        pending = pending | cpu16_pkg::onehot16(w_rd[l]);
      end
    end
  end

  assign wb_busy = ($countones(w_valid) >= 2);

  assign x0  = '0;
  assign x1  = r_x[1];
  assign x2  = r_x[2];
  assign x3  = r_x[3];
  assign x4  = r_x[4];
  assign x5  = r_x[5];
  assign x6  = r_x[6];
  assign x7  = r_x[7];
  assign x8  = r_x[8];
  assign x9  = r_x[9];
  assign x10 = r_x[10];
  assign x11 = r_x[11];
  assign x12 = r_x[12];
  assign x13 = r_x[13];
  assign x14 = r_x[14];
  assign x15 = r_x[15];

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back end of the 16-bit CPU register file. Accepts results from the four execution lanes (d0..d3) over valid/ready handshakes, arbitrates round-robin, commits one register write per cycle, and holds the architectural registers x0..x15 that feed the rs1/rs2 decode read stages. A pending-write mask is exported for hazard detection in decode.

## Interface

Parameters:
- DATA_W, 16, register and result width
- NUM_REGS, 16, architectural registers; the index is log2(NUM_REGS) = 4 bits
- NUM_LANES, 4, result lanes d0..d3

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- wb_valid_d0..wb_valid_d3  in  1 each  lane holds a result to write
- wb_rd_d0..wb_rd_d3  in  4 each  destination register index
- wb_data_d0..wb_data_d3  in  16 each  result data
- wb_ready_d0..wb_ready_d3  out  1 each  lane is granted this cycle
- x0..x15  out  16 each  architectural register contents (registered)
- pending  out  16  bit r set when any lane has wb_valid high with wb_rd == r
- wb_busy  out  1  more than one lane valid this cycle (back-pressure indicator)

## Operation

- Handshake: a lane transfers when wb_valid and wb_ready are both high at a rising edge. While wb_valid is high and wb_ready is low, the lane must hold wb_rd and wb_data stable. A lane may drop wb_valid only after its transfer.
- Arbitration: at most one wb_ready is high per cycle. The grant goes to the first valid lane at or after rr_ptr, in order d0→d1→d2→d3→d0. The grant is combinational from the wb_valid inputs and rr_ptr.
- rr_ptr: a 2-bit register. On a grant to lane g it loads (g+1) mod 4, wrapping 3→0. With no grant it holds.
- Commit: on a transfer, x[wb_rd] takes wb_data at that edge.
- x0 is hardwired to zero. Writes to rd = 0 complete the handshake, release the lane and advance rr_ptr, but leave x0 = 0.
- pending: combinational OR over the four lanes of (wb_valid_i ? onehot(wb_rd_i) : 0). Bit 0 follows the same rule.
- wb_busy: combinational; high when popcount(wb_valid) ≥ 2.
- Same rd on multiple lanes: writes serialize in grant order, so the last-granted lane's value persists.
- Reset: when rst_n is low at an edge, x1..x15 = 0 and rr_ptr = 0, and no write commits that cycle even if a handshake is asserted. wb_ready is forced low while rst_n is low. pending and wb_busy still follow the inputs. A lane that was waiting when reset asserted keeps its request and is arbitrated normally once rst_n is high.

## Timing

- Latency: a value transferred at edge N appears on x[rd] immediately after edge N, so it is visible to decode in cycle N+1. There is no internal bypass from wb_data to x outputs.
- Single-lane throughput: one transfer per cycle when the lane keeps wb_valid high.
- With all four lanes continuously valid, each lane gets one grant every 4 cycles.
- Worst-case wait for a valid lane is 3 cycles.
- The wb_ready to wb_valid path is combinational in one direction only. Lanes must not derive wb_valid from wb_ready.
- Reset values: x0..x15 = 0, rr_ptr = 0. wb_ready = 0 during reset. pending and wb_busy are combinational from the inputs.

## Structure

- Shared package cpu16_pkg holds:
  - DATA_W, REG_IDX_W = 4, NUM_REGS, NUM_LANES
  - typedef reg_idx_t (4 bits), word_t (16 bits), lane_idx_t (2 bits)
  - a onehot16 helper function
- One sub-module, rr_arbiter4: inputs clk, rst_n, req[3:0]; outputs gnt[3:0] and gnt_idx[1:0]. It owns rr_ptr.
- The register array, write-enable decode and pending mask live in regfile_writeback.

## Test plan

- After reset, lane d1 writes rd=5, data=16'hBEEF with a single-cycle handshake. Expected: wb_ready_d1 = 1 that cycle, and x5 = 16'hBEEF on the next cycle with all other registers 0.
- All four lanes valid from reset with rd=1..4 and data 16'h0011, 16'h0022, 16'h0033, 16'h0044. Expected: grants in order d0, d1, d2, d3 on consecutive cycles, wb_busy high for the first three of those cycles, and after 4 cycles x1..x4 hold the four values.
- Lanes d2 and d3 both write rd=7, with d2 = 16'h1234 and d3 = 16'h5678, and rr_ptr = 3. Expected: d3 is granted first and d2 second, leaving x7 = 16'h1234.
- Lane d0 writes rd=0, data=16'hFFFF. Expected: the handshake completes and rr_ptr becomes 1, while x0 stays 0. pending[0] is high during the request.
- Lane d2 is valid with rd=9 and data 16'hAAAA, and rst_n is driven low for one cycle mid-request. Expected: x9 stays 0 and wb_ready_d2 = 0 during reset. On the first cycle after reset, d2 is granted and x9 = 16'hAAAA, while pending[9] stays high until the transfer.
